// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencing, interrupt entry and CP0 Status/Cause/EPC/PRId for the F stage.
// Define ERET_FWD_EN to forward in-flight mtc0 EPC data to ERET instead of stalling.
module pc_redirect_ctrl #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] PRID        = 32'h0000_4D50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic        hazard_stall,
    input  logic        d_branch,
    input  logic        d_jump,
    input  logic        d_jr,
    input  logic        d_eret,
    input  logic [31:0] m_pc,
    input  logic        m_valid,
    input  logic        m_in_delay,
    input  logic        e_mtc0_epc,
    input  logic        m_mtc0_epc,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic [2:0]  pc_sel,
    output logic        pc_en,
    output logic        intbranch,
    output logic        flush_all,
    output logic [29:0] epc,
    output logic [1:0]  fderet,
    output logic        eret_stall
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ARM  = 2'd1,
        TAKE = 2'd2
    } state_t;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;
    localparam logic [4:0] ADDR_PRID   = 5'd15;

    localparam logic [2:0] SEL_PC4    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_REG    = 3'd2;
    localparam logic [2:0] SEL_JUMP   = 3'd3;
    localparam logic [2:0] SEL_EPC    = 3'd4;

    state_t      state;
    logic [5:0]  sync_ff [SYNC_STAGES];
    logic [5:0]  ip;
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic        req;
    logic        take_now;
    logic        eret_accept;
    logic [1:0]  fderet_raw;
    logic [31:0] epc_capture;

    // NOTE: every flop, including each synchronizer stage, is cleared by the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= hw_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign ip  = sync_ff[SYNC_STAGES-1];
    assign req = ie & ~exl & (|(ip & im));

`ifdef ERET_FWD_EN
    assign eret_stall = 1'b0;

    always_comb begin
        // NOTE: combinational outputs get a default first so no path can infer a latch.
        fderet_raw = 2'd0;
        if (e_mtc0_epc) begin
            fderet_raw = 2'd1;
        end else if (m_mtc0_epc) begin
            fderet_raw = 2'd2;
        end
    end
`else
    assign eret_stall = d_eret & (e_mtc0_epc | m_mtc0_epc);
    assign fderet_raw = 2'd0;
`endif

    assign fderet = reset ? 2'd0 : fderet_raw;

    // RUN defers to an ERET in decode; ARM only waits for a real instruction in M.
    assign take_now = ((state == RUN) & req & ~d_eret & m_valid)
                    | ((state == ARM) & req & m_valid);

    // The D-stage instruction is flushed during TAKE, so an ERET there does not retire.
    assign eret_accept = d_eret & ~hazard_stall & ~eret_stall & (state != TAKE);

    assign epc_capture = m_in_delay ? (m_pc - 32'd4) : m_pc;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            intbranch <= 1'b0;
            flush_all <= 1'b0;
        end else begin
            intbranch <= take_now;
            flush_all <= take_now;
            case (state)
                RUN: begin
                    if (take_now) begin
                        state <= TAKE;
                    end else if (req & ~d_eret) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (take_now) begin
                        state <= TAKE;
                    end else if (!req) begin
                        state <= RUN;
                    end
                end
                TAKE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
            bd  <= 1'b0;
            epc <= '0;
        end else begin
            if (cp0_we && cp0_addr == ADDR_STATUS) begin
                im  <= cp0_wdata[15:10];
                exl <= cp0_wdata[1];
                ie  <= cp0_wdata[0];
            end
            if (cp0_we && cp0_addr == ADDR_EPC) begin
                epc <= cp0_wdata[31:2];
            end
            if (eret_accept) begin
                exl <= 1'b0;
            end
            // Interrupt entry is written last so it wins over software writes this cycle.
            if (take_now) begin
                epc <= epc_capture[31:2];
                bd  <= m_in_delay;
                exl <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_sel = SEL_PC4;
        if (!reset && state != TAKE) begin
            if (d_eret) begin
                pc_sel = SEL_EPC;
            end else if (d_jr) begin
                pc_sel = SEL_REG;
            end else if (d_jump) begin
                pc_sel = SEL_JUMP;
            end else if (d_branch) begin
                pc_sel = SEL_BRANCH;
            end
        end
    end

    always_comb begin
        pc_en = 1'b1;
        if (!reset && state != TAKE) begin
            pc_en = ~hazard_stall & ~eret_stall;
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_STATUS: cp0_rdata = {16'd0, im, 8'd0, exl, ie};
            ADDR_CAUSE:  cp0_rdata = {bd, 15'd0, ip, 10'd0};
            ADDR_EPC:    cp0_rdata = {epc, 2'b00};
            ADDR_PRID:   cp0_rdata = PRID;
            default:     cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed and randomized bench for pc_redirect_ctrl against a behavioural CP0/PC model.
module tb_pc_redirect_ctrl;

    localparam int          SYNC = 2;
    localparam logic [31:0] PRID = 32'h0000_4D50;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic        hazard_stall;
    logic        d_branch, d_jump, d_jr, d_eret;
    logic [31:0] m_pc;
    logic        m_valid, m_in_delay;
    logic        e_mtc0_epc, m_mtc0_epc;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [2:0]  pc_sel;
    logic        pc_en, intbranch, flush_all;
    logic [29:0] epc;
    logic [1:0]  fderet;
    logic        eret_stall;

    pc_redirect_ctrl #(.SYNC_STAGES(SYNC), .PRID(PRID)) dut (
        .clk(clk), .reset(reset), .hw_int(hw_int), .hazard_stall(hazard_stall),
        .d_branch(d_branch), .d_jump(d_jump), .d_jr(d_jr), .d_eret(d_eret),
        .m_pc(m_pc), .m_valid(m_valid), .m_in_delay(m_in_delay),
        .e_mtc0_epc(e_mtc0_epc), .m_mtc0_epc(m_mtc0_epc),
        .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .pc_sel(pc_sel), .pc_en(pc_en),
        .intbranch(intbranch), .flush_all(flush_all), .epc(epc),
        .fderet(fderet), .eret_stall(eret_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: architectural registers plus "interrupt pending" bookkeeping.
    logic [5:0]  mim;
    logic        mexl, mie, mbd;
    logic [31:0] mepc;
    logic [5:0]  hist[$];
    bit          mtaking, mwaiting;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] mip();
        return hist[SYNC-1];
    endfunction

    function automatic logic mreq();
        return mie & ~mexl & (|(mip() & mim));
    endfunction

    function automatic logic [2:0] exp_sel();
        if (d_eret)   return 3'd4;
        if (d_jr)     return 3'd2;
        if (d_jump)   return 3'd3;
        if (d_branch) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic exp_stall();
`ifdef ERET_FWD_EN
        return 1'b0;
`else
        return d_eret & (e_mtc0_epc | m_mtc0_epc);
`endif
    endfunction

    function automatic logic [1:0] exp_fderet();
`ifdef ERET_FWD_EN
        if (e_mtc0_epc) return 2'd1;
        if (m_mtc0_epc) return 2'd2;
`endif
        return 2'd0;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        case (a)
            5'd12:   return {16'd0, mim, 8'd0, mexl, mie};
            5'd13:   return {mbd, 15'd0, mip(), 10'd0};
            5'd14:   return mepc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        mim = '0; mexl = 0; mie = 0; mbd = 0; mepc = '0;
        mtaking = 0; mwaiting = 0;
        hist = {};
        for (int i = 0; i < SYNC; i++) hist.push_back(6'd0);
    endtask

    task automatic model_edge();
        logic r;
        bit   enter, accept;
        r = mreq();
        enter = 0;
        accept = 0;
        if (mtaking) begin
            mtaking = 0;
        end else begin
            if (mwaiting) begin
                if (!r) mwaiting = 0;
                else if (m_valid) enter = 1;
            end else if (r && !d_eret) begin
                if (m_valid) enter = 1;
                else mwaiting = 1;
            end
            accept = d_eret && !hazard_stall && !exp_stall();
        end
        if (cp0_we && cp0_addr == 5'd12) begin
            mim = cp0_wdata[15:10]; mexl = cp0_wdata[1]; mie = cp0_wdata[0];
        end
        if (cp0_we && cp0_addr == 5'd14) mepc = cp0_wdata & 32'hFFFF_FFFC;
        if (accept) mexl = 0;
        if (enter) begin
            mepc = (m_in_delay ? m_pc - 32'd4 : m_pc) & 32'hFFFF_FFFC;
            mbd = m_in_delay;
            mexl = 1;
            mtaking = 1;
            mwaiting = 0;
        end
        hist.push_front(hw_int);
        hist.delete(SYNC);
    endtask

    task automatic check_outputs();
        check("intbranch", intbranch, mtaking);
        check("flush_all", flush_all, mtaking);
        check("epc", epc, mepc[31:2]);
        check("cp0_rdata", cp0_rdata, exp_rdata(cp0_addr));
        check("eret_stall", eret_stall, exp_stall());
        check("fderet", fderet, exp_fderet());
        if (mtaking) begin
            check("pc_en_take", pc_en, 1);
        end else begin
            check("pc_sel", pc_sel, exp_sel());
            check("pc_en", pc_en, !hazard_stall && !exp_stall());
        end
    endtask

    // Inputs are driven at posedge+1; outputs are checked at the falling edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        hazard_stall = 0; d_branch = 0; d_jump = 0; d_jr = 0; d_eret = 0;
        e_mtc0_epc = 0; m_mtc0_epc = 0; cp0_we = 0; cp0_wdata = '0;
    endtask

    task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_addr = a; cp0_wdata = d;
        cycle();
        cp0_we = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        #1;
        check("rst_pc_sel", pc_sel, 3'd0);
        check("rst_pc_en", pc_en, 1);
        check("rst_intbranch", intbranch, 0);
        check("rst_flush", flush_all, 0);
        check("rst_fderet", fderet, 2'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        reset = 1; hw_int = 0; m_pc = 0; m_valid = 1; m_in_delay = 0; cp0_addr = 5'd12;
        idle();
        d_eret = 1; d_jr = 1;
        apply_reset();
        check("rst_status", cp0_rdata, 32'd0);
        idle();

        // Interrupt, no delay slot: SYNC_STAGES+1 cycle latency.
        cp0_write(5'd12, 32'h0000_0401);
        m_pc = 32'h3010; m_valid = 1; m_in_delay = 0; hw_int = 6'd1;
        cycle(); cycle();
        check("int_early", intbranch, 0);
        cycle();
        check("int_latency", intbranch, 1);
        check("int_epc", epc, 30'(32'h3010 >> 2));
        cp0_addr = 5'd13; #1;
        check("int_cause", cp0_rdata, 32'h0000_0400);
        cycle();
        cp0_addr = 5'd12; #1;
        check("int_exl", cp0_rdata, 32'h0000_0403);
        hw_int = 0;
        cycle(); cycle(); cycle();

        // Delay-slot interrupt.
        cp0_write(5'd12, 32'h0000_0401);
        m_pc = 32'h3024; m_in_delay = 1; hw_int = 6'd1;
        cycle(); cycle(); cycle();
        check("ds_take", intbranch, 1);
        check("ds_epc", epc, 30'(32'h3020 >> 2));
        cp0_addr = 5'd13; #1;
        check("ds_cause", cp0_rdata, 32'h8000_0400);
        hw_int = 0; m_in_delay = 0;
        cycle(); cycle(); cycle();

        // Bubble wait in ARM.
        m_valid = 0;
        cp0_write(5'd12, 32'h0000_0401);
        hw_int = 6'd1;
        cycle(); cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("arm_hold", intbranch, 0);
        end
        m_valid = 1;
        cycle();
        check("arm_take", intbranch, 1);
        cycle();

        // ERET with a pending interrupt behind it.
        cp0_write(5'd14, 32'h0000_3040);
        d_eret = 1; cp0_addr = 5'd12; #1;
        check("eret_sel", pc_sel, 3'd4);
        check("eret_en", pc_en, 1);
        check("eret_epc", epc, 30'(32'h3040 >> 2));
        cycle();
        d_eret = 0; #1;
        check("eret_exl", cp0_rdata, 32'h0000_0401);
        check("eret_noint", intbranch, 0);
        cycle();
        check("eret_then_int", intbranch, 1);
        hw_int = 0;
        cp0_write(5'd12, 32'h0);
        cycle(); cycle(); cycle();

        // ERET source forwarding / stall.
        d_eret = 1; e_mtc0_epc = 1; m_mtc0_epc = 1; #1;
`ifdef ERET_FWD_EN
        check("fwd_e", fderet, 2'd1);
        check("fwd_en", pc_en, 1);
`else
        check("stall_both", eret_stall, 1);
        check("stall_en", pc_en, 0);
`endif
        cycle();
        e_mtc0_epc = 0; #1;
`ifdef ERET_FWD_EN
        check("fwd_m", fderet, 2'd2);
`else
        check("stall_m", pc_en, 0);
`endif
        cycle();
        m_mtc0_epc = 0; #1;
        check("fwd_clear_en", pc_en, 1);
        check("fwd_clear_stall", eret_stall, 0);
        cycle();
        idle();

        // Priority with hazard stall.
        d_jr = 1; d_branch = 1; hazard_stall = 1; #1;
        check("prio_sel", pc_sel, 3'd2);
        check("prio_en", pc_en, 0);
        cycle();
        idle();

        // Reset mid-TAKE.
        cp0_write(5'd12, 32'h0000_0401);
        m_valid = 1; hw_int = 6'd1;
        cycle(); cycle(); cycle();
        check("pre_reset_take", intbranch, 1);
        cp0_addr = 5'd12;
        apply_reset();
        check("post_reset_status", cp0_rdata, 32'd0);
        check("post_reset_epc", epc, 30'd0);
        hw_int = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (i % 400 == 399) apply_reset();
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            hazard_stall = ($urandom_range(0, 4) == 0);
            d_branch = ($urandom_range(0, 3) == 0);
            d_jump = ($urandom_range(0, 3) == 0);
            d_jr = ($urandom_range(0, 3) == 0);
            d_eret = ($urandom_range(0, 5) == 0);
            e_mtc0_epc = ($urandom_range(0, 3) == 0);
            m_mtc0_epc = ($urandom_range(0, 3) == 0);
            m_pc = $urandom;
            m_valid = ($urandom_range(0, 3) != 0);
            m_in_delay = ($urandom_range(0, 2) == 0);
            cp0_we = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0:       cp0_addr = 5'd12;
                1:       cp0_addr = 5'd13;
                2:       cp0_addr = 5'd14;
                3:       cp0_addr = 5'd15;
                default: cp0_addr = 5'($urandom);
            endcase
            cp0_wdata = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Controller that sequences the fetch-stage program counter.
- Each cycle it decides the PC next-address select and the PC enable, and when to force the interrupt vector.
- Owns the exception registers Status, Cause, EPC and PRId, and selects the source of the ERET return address.
- Sits between the decode-stage control signals, the hazard unit, the M-stage commit information and the PC register.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on each hw_int line (minimum 1)
PRID, 32'h0000_4D50, read-only value returned for CP0 register 15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
hw_int  in  6  raw external interrupt lines, asynchronous to clk
hazard_stall  in  1  hazard unit freezes F/D
d_branch  in  1  D-stage conditional branch
d_jump  in  1  D-stage j/jal
d_jr  in  1  D-stage jr/jalr
d_eret  in  1  D-stage eret
m_pc  in  32  PC of the M-stage instruction
m_valid  in  1  M-stage holds a real instruction, not a bubble
m_in_delay  in  1  M-stage instruction is in a branch delay slot
e_mtc0_epc  in  1  E-stage instruction is mtc0 to EPC
m_mtc0_epc  in  1  M-stage instruction is mtc0 to EPC
cp0_we  in  1  CP0 write strobe, M stage
cp0_addr  in  5  CP0 register number
cp0_wdata  in  32  CP0 write data
cp0_rdata  out  32  CP0 read data, combinational
pc_sel  out  3  0=pc+4, 1=branch, 2=register, 3=jump, 4=EPC
pc_en  out  1  PC load enable
intbranch  out  1  force PC to the handler vector
flush_all  out  1  kill F, D, E and M
epc  out  30  EPC[31:2]
fderet  out  2  ERET source: 0=EPC reg, 1=E-stage data, 2=M-stage data
eret_stall  out  1  ERET must wait; always 0 when ERET_FWD_EN is defined

Behaviour:
- Reset (async, active-high). Clears all of the following:
  - state = RUN
  - Status IM[15:10], EXL[1], IE[0]
  - Cause BD[31], IP[15:10]
  - EPC
  - all synchronizer flops
- Outputs during reset: pc_sel=0, pc_en=1, intbranch=0, flush_all=0, fderet=0.
- Synchronizer: IP[i] is hw_int[i] delayed by SYNC_STAGES flops. IP is read-only; writes to Cause are ignored.
- Interrupt request: req = IE & ~EXL & |(IP & IM).
- CP0 writes (cp0_we):
  - addr 12 updates IM, EXL and IE.
  - addr 14 updates EPC[31:2].
  - Writes to any other address are ignored.
- CP0 reads:
  - 12 -> {16'b0, IM, 8'b0, EXL, IE}
  - 13 -> {BD, 15'b0, IP, 10'b0}
  - 14 -> {EPC, 2'b00}
  - 15 -> PRID
  - any other address -> 0
- FSM states: RUN, ARM, TAKE.
  - RUN: if req & ~d_eret and m_valid=1, go to TAKE. If req & ~d_eret and m_valid=0, go to ARM.
  - ARM: hold until m_valid=1, then go to TAKE. If req drops in ARM (IM or IE cleared), return to RUN.
  - TAKE lasts exactly 1 cycle, then returns to RUN.
- On the edge entering TAKE:
  - EPC <= m_in_delay ? m_pc-4 : m_pc (bits [31:2], wrap modulo 2^32)
  - BD <= m_in_delay
  - EXL <= 1
- The TAKE capture overrides a cp0_we write to Status or EPC in the same cycle.
- Outputs in TAKE: intbranch=1, flush_all=1, pc_en=1.
- pc_sel priority in RUN/ARM: d_eret(4) > d_jr(2) > d_jump(3) > d_branch(1) > 0.
- pc_en = ~hazard_stall & ~eret_stall.
- ERET: on the cycle d_eret is accepted (pc_en=1), EXL is cleared at the next edge. req is masked in that same cycle, so an ERET is never interrupted mid-redirect.
- fderet (when forwarding is enabled):
  - e_mtc0_epc=1 -> 1 (the younger writer wins)
  - else m_mtc0_epc=1 -> 2
  - else 0
- Latency: an interrupt edge on hw_int causes intbranch to rise SYNC_STAGES+1 cycles later (m_valid=1, req enabled). The PC loads the vector on the following edge.
- Reset asserted in ARM or TAKE aborts immediately; EPC is not updated.

Optional Feature:
ERET_FWD_EN
- Defined: fderet is driven as specified above and eret_stall=0.
- Undefined: fderet is tied to 0. eret_stall = d_eret & (e_mtc0_epc | m_mtc0_epc), which holds pc_en=0 until the pending EPC write reaches the register.

Test Plan:
- Interrupt, no delay slot: Status=0x0000_0401, m_pc=0x3010, m_valid=1, m_in_delay=0; pulse hw_int[0] -> intbranch=1 exactly 3 cycles later (SYNC_STAGES=2), EPC=0x3010, EXL=1, cp0_rdata(13)=0x0000_0400 (IP[10]=1, BD=0).
- Delay-slot interrupt: as above with m_in_delay=1, m_pc=0x3024 -> EPC=0x3020, Cause[31]=1.
- Bubble wait: req with m_valid=0 for 3 cycles -> FSM in ARM, intbranch=0; m_valid rises -> TAKE next cycle.
- ERET: d_eret=1, EXL=1, EPC=0x3040 -> pc_sel=4, pc_en=1; EXL=0 next cycle; pending IP held off for that cycle.
- Forwarding: d_eret with e_mtc0_epc=1 and m_mtc0_epc=1 -> fderet=1. Without ERET_FWD_EN -> eret_stall=1, pc_en=0, until both flags clear.
- Priority/stall: d_jr=1, d_branch=1, hazard_stall=1 -> pc_sel=2, pc_en=0. Async reset asserted mid-TAKE -> intbranch=0 immediately and Status reads 0.
